// File: rtl/da_slice_tx.sv
// rtl/da_slice_tx.sv - bit-serial DA slice transmitter, optional tap flush via DA_SLICE_TX_FLUSH_EN
module da_slice_tx #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [3:0]   m_slice,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_first,
  output logic         m_last
`ifdef DA_SLICE_TX_FLUSH_EN
  ,
  input  logic         flush
`endif
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  hold;
  logic          hold_full;
  logic [W-1:0]  x0, x1, x2, x3;
  logic [W-1:0]  sh0, sh1, sh2, sh3;
  logic [BW-1:0] bcnt;
  logic          accept;
  logic          last_bit;
  logic          do_load;
  logic          do_shift;
  logic          clear_taps;

  assign accept   = s_valid && !hold_full;
  assign last_bit = (bcnt == BW'(W - 1));

  // Outputs are decoded only from registers, so no input reaches an output combinationally.
  assign s_ready = !hold_full;
  assign m_valid = (state == SEND);
  assign m_slice = {sh3[0], sh2[0], sh1[0], sh0[0]};
  assign m_first = m_valid && (bcnt == '0);
  assign m_last  = m_valid && last_bit;

`ifdef DA_SLICE_TX_FLUSH_EN
  assign clear_taps = flush && (state == IDLE) && !hold_full;
`else
  assign clear_taps = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus frame-load / shift strobes for the datapath.
  always_comb begin
    state_nx = state;
    do_load  = 1'b0;
    do_shift = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          do_load  = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (!last_bit) begin
            do_shift = 1'b1;
          end else if (hold_full) begin
            do_load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Single-sample input buffer; a new acceptance wins over the clear from a frame load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= s_data;
      hold_full <= 1'b1;
    end else if (do_load) begin
      hold_full <= 1'b0;
    end
  end

  // Delay line advances once per frame; sh* are the per-frame working copies shifted LSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0   <= '0;
      x1   <= '0;
      x2   <= '0;
      x3   <= '0;
      sh0  <= '0;
      sh1  <= '0;
      sh2  <= '0;
      sh3  <= '0;
      bcnt <= '0;
    end else if (do_load) begin
      x3   <= x2;
      x2   <= x1;
      x1   <= x0;
      x0   <= hold;
      sh0  <= hold;
      sh1  <= x0;
      sh2  <= x1;
      sh3  <= x2;
      bcnt <= '0;
    end else if (do_shift) begin
      sh0  <= sh0 >> 1;
      sh1  <= sh1 >> 1;
      sh2  <= sh2 >> 1;
      sh3  <= sh3 >> 1;
      bcnt <= bcnt + BW'(1);
    end else if (clear_taps) begin
      x0   <= '0;
      x1   <= '0;
      x2   <= '0;
      x3   <= '0;
    end
  end

endmodule

// File: tb/tb_da_slice_tx.sv
// tb/tb_da_slice_tx.sv - scoreboard bench for da_slice_tx, flush steps under DA_SLICE_TX_FLUSH_EN
module tb_da_slice_tx;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [3:0]   m_slice;
  logic         m_valid;
  logic         m_ready;
  logic         m_first;
  logic         m_last;
`ifdef DA_SLICE_TX_FLUSH_EN
  logic         flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int run      = 0;
  int max_run  = 0;

  logic [5:0]   exp_q[$];
  logic [5:0]   e;
  logic [W-1:0] t0, t1, t2, t3;
  logic [3:0]   pat;

  da_slice_tx #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_slice (m_slice),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_first (m_first),
    .m_last  (m_last)
`ifdef DA_SLICE_TX_FLUSH_EN
    ,
    .flush   (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: delay line of accepted samples, expanding each into W expected slices.
  task automatic push_sample(input logic [W-1:0] s);
    t3 = t2;
    t2 = t1;
    t1 = t0;
    t0 = s;
    for (int b = 0; b < W; b++) begin
      exp_q.push_back({(b == W - 1) ? 1'b1 : 1'b0, (b == 0) ? 1'b1 : 1'b0,
                       t3[b], t2[b], t1[b], t0[b]});
    end
  endtask

  task automatic send(input logic [W-1:0] s);
    bit acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = s;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    if (acc) push_sample(s);
    else check("send_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic drain;
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_valid) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !m_valid), 32'd1);
  endtask

  // Scoreboard monitor: compare every presented slice, pop only on handshake.
  always @(negedge clk) begin
    if (reset && m_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("unexpected_slice", 32'(m_slice), 32'hFFFF_FFFF);
      end else begin
        e = exp_q[0];
        check("slice", 32'(m_slice), 32'(e[3:0]));
        check("first", 32'(m_first), 32'(e[4]));
        check("last",  32'(m_last),  32'(e[5]));
        if (m_ready) void'(exp_q.pop_front());
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
`ifdef DA_SLICE_TX_FLUSH_EN
    flush = 1'b0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_first", 32'(m_first), 32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_m_slice", 32'(m_slice), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single sample 0xA: latency and first frame.
    send(4'hA);
    check("lat_m_valid_low", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_m_valid_high", 32'(m_valid), 32'd1);
    check("lat_m_first", 32'(m_first), 32'd1);
    check("lat_s_ready", 32'(s_ready), 32'd1);
    drain();

    // Second sample 0x3 sees 0xA in tap 1.
    send(4'h3);
    drain();

    // Back-to-back 1..5: no bubble between frames.
    max_run = 0;
    for (int i = 1; i <= 5; i++) send(W'(i));
    drain();
    check("b2b_run", 32'(max_run), 32'(5 * W));

    // Backpressure 1,0,0,1 with a second sample parked in hold.
    send(4'h7);
    send(4'h9);
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      m_ready = pat[i];
      @(negedge clk);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    drain();

    // Reset at slice 2 of a frame.
    send(4'h5);
    repeat (3) @(posedge clk);
    #1;
    check("mid_bcnt2_valid", 32'(m_valid), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;
    #1;
    check("mid_s_ready", 32'(s_ready), 32'd1);
    check("mid_m_valid", 32'(m_valid), 32'd0);
    check("mid_m_first", 32'(m_first), 32'd0);
    check("mid_m_last",  32'(m_last),  32'd0);
    check("mid_m_slice", 32'(m_slice), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(4'hF);
    drain();

`ifdef DA_SLICE_TX_FLUSH_EN
    // Flush: ignored during SEND, clears taps in IDLE.
    for (int i = 1; i <= 4; i++) send(W'(i));
    drain();
    send(4'h7);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drain();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;
    send(4'h6);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
